// File: rtl/sdram_responder_pkg.sv
// Shared definitions for the SDR SDRAM responder: command encodings,
// bank/burst state enums and mode-register field decoders.
package sdram_responder_pkg;

    // {ras_n, cas_n, we_n} with cs_n low
    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
    localparam logic [2:0] CMD_BST       = 3'b110;

    typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_t;

    typedef enum logic [1:0] {BURST_IDLE, BURST_RD, BURST_WR} burst_state_t;

    function automatic logic [3:0] decode_bl(input logic [2:0] field);
        case (field)
            3'b001:  return 4'd2;
            3'b010:  return 4'd4;
            3'b011:  return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [1:0] decode_cl(input logic [2:0] field);
        return (field == 3'd2) ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/sdram_responder_mem.sv
// Byte-enabled single-port synchronous RAM of 16-bit words (M10K style).
// Read data is registered; a write returns the old word on the same cycle.
module sdram_responder_mem #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    we,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we[0]) mem[addr][7:0]  <= wdata[7:0];
            if (we[1]) mem[addr][15:8] <= wdata[15:8];
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sdram_responder.sv
// Device-side model of an SDR SDRAM for loopback builds. Define
// SDRAM_RESPONDER_CHECK_EN to compile in the protocol/timing checker on err.
module sdram_responder
    import sdram_responder_pkg::*;
#(
    parameter int ROW_KEEP = 4,
    parameter int COL_KEEP = 6,
    parameter int T_RCD    = 3,
    parameter int T_RP     = 3,
    parameter int T_RFC    = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dram_cke,
    input  logic        dram_cs_n,
    input  logic        dram_ras_n,
    input  logic        dram_cas_n,
    input  logic        dram_we_n,
    input  logic [1:0]  dram_ba,
    input  logic [12:0] dram_addr,
    input  logic [1:0]  dram_dqm,
    input  logic [15:0] dram_dq_in,
    output logic [15:0] dram_dq_out,
    output logic        dram_dq_oe,
    output logic        err
);

    localparam int AW = 2 + ROW_KEEP + COL_KEEP;

    logic [2:0]          cmd;
    bank_state_t         bank_st  [4];
    logic [ROW_KEEP-1:0] bank_row [4];
    logic [3:0]          mode_bl;
    logic [1:0]          mode_cl;

    burst_state_t        burst_st;
    logic [1:0]          burst_ba;
    logic [ROW_KEEP-1:0] burst_row;
    logic [COL_KEEP-1:0] burst_col;
    logic [2:0]          beat_cnt;
    logic [3:0]          burst_bl;
    logic                burst_ap;

    logic                rd_v0, rd_v1;
    logic [15:0]         rd_d1;
    logic [15:0]         mem_q;

    logic                bank_open, new_rd, new_wr, burst_stop, burst_cont, last_beat;
    logic                beat_rd, beat_wr;
    logic [1:0]          beat_ba;
    logic [ROW_KEEP-1:0] beat_row;
    logic [COL_KEEP-1:0] beat_col, wrap_mask;
    logic                addr_unused;

    assign cmd         = dram_cs_n ? CMD_NOP : {dram_ras_n, dram_cas_n, dram_we_n};
    assign addr_unused = ^dram_addr;

    // Beat 0 comes straight from the command; later beats from the burst engine.
    always_comb begin
        bank_open  = (bank_st[dram_ba] == BANK_ACTIVE);
        new_rd     = (cmd == CMD_READ)  && bank_open;
        new_wr     = (cmd == CMD_WRITE) && bank_open;
        burst_stop = (cmd == CMD_BST) ||
                     ((cmd == CMD_PRECHARGE) && (dram_addr[10] || dram_ba == burst_ba));
        burst_cont = (burst_st != BURST_IDLE) && !new_rd && !new_wr && !burst_stop;
        last_beat  = burst_cont && ({1'b0, beat_cnt} == burst_bl - 4'd1);
        wrap_mask  = COL_KEEP'(burst_bl - 4'd1);
        beat_ba    = burst_ba;
        beat_row   = burst_row;
        beat_col   = (burst_col & ~wrap_mask) |
                     ((burst_col + COL_KEEP'(beat_cnt)) & wrap_mask);
        beat_rd    = burst_cont && (burst_st == BURST_RD);
        beat_wr    = burst_cont && (burst_st == BURST_WR);
        if (new_rd || new_wr) begin
            beat_ba  = dram_ba;
            beat_row = bank_row[dram_ba];
            beat_col = dram_addr[COL_KEEP-1:0];
            beat_rd  = new_rd;
            beat_wr  = new_wr;
        end
    end

    sdram_responder_mem #(.AW(AW)) u_mem (
        .clk   (clk),
        .en    (dram_cke),
        .addr  ({beat_ba, beat_row, beat_col}),
        .we    ({2{beat_wr}} & ~dram_dqm),
        .wdata (dram_dq_in),
        .rdata (mem_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                bank_st[i]  <= BANK_IDLE;
                bank_row[i] <= '0;
            end
            mode_bl     <= 4'd1;
            mode_cl     <= 2'd3;
            burst_st    <= BURST_IDLE;
            burst_ba    <= '0;
            burst_row   <= '0;
            burst_col   <= '0;
            beat_cnt    <= '0;
            burst_bl    <= 4'd1;
            burst_ap    <= 1'b0;
            rd_v0       <= 1'b0;
            rd_v1       <= 1'b0;
            rd_d1       <= '0;
            dram_dq_out <= '0;
            dram_dq_oe  <= 1'b0;
        end else if (dram_cke) begin
            case (cmd)
                CMD_ACTIVE: begin
                    bank_st[dram_ba]  <= BANK_ACTIVE;
                    bank_row[dram_ba] <= dram_addr[ROW_KEEP-1:0];
                end
                CMD_PRECHARGE: begin
                    for (int i = 0; i < 4; i++)
                        if (dram_addr[10] || dram_ba == 2'(i)) bank_st[i] <= BANK_IDLE;
                end
                CMD_LOAD_MODE: begin
                    mode_bl <= decode_bl(dram_addr[2:0]);
                    mode_cl <= decode_cl(dram_addr[6:4]);
                end
                default: ;
            endcase

            // Auto-precharge closes after the command decode so it wins a same-edge ACTIVE.
            if (new_rd || new_wr) begin
                burst_st  <= (mode_bl == 4'd1) ? BURST_IDLE : (new_rd ? BURST_RD : BURST_WR);
                beat_cnt  <= 3'd1;
                burst_ba  <= dram_ba;
                burst_row <= bank_row[dram_ba];
                burst_col <= dram_addr[COL_KEEP-1:0];
                burst_bl  <= mode_bl;
                burst_ap  <= dram_addr[10];
                if (mode_bl == 4'd1 && dram_addr[10]) bank_st[dram_ba] <= BANK_IDLE;
            end else if (burst_st != BURST_IDLE && burst_stop) begin
                burst_st <= BURST_IDLE;
            end else if (burst_cont) begin
                if (last_beat) begin
                    burst_st <= BURST_IDLE;
                    if (burst_ap) bank_st[burst_ba] <= BANK_IDLE;
                end else begin
                    beat_cnt <= beat_cnt + 3'd1;
                end
            end

            rd_v0 <= beat_rd && (dram_dqm == 2'b00);
            if (new_wr) begin
                rd_v1      <= 1'b0;
                dram_dq_oe <= 1'b0;
            end else begin
                rd_v1 <= rd_v0;
                rd_d1 <= mem_q;
                if (mode_cl == 2'd2) begin
                    dram_dq_oe  <= rd_v0;
                    dram_dq_out <= mem_q;
                end else begin
                    dram_dq_oe  <= rd_v1;
                    dram_dq_out <= rd_d1;
                end
            end
        end
    end

`ifdef SDRAM_RESPONDER_CHECK_EN
    localparam int CW = 8;

    logic [CW-1:0] rcd_cnt [4];
    logic [CW-1:0] rp_cnt  [4];
    logic [CW-1:0] rfc_cnt;
    logic          viol, any_open;

    always_comb begin
        any_open = 1'b0;
        for (int i = 0; i < 4; i++)
            if (bank_st[i] == BANK_ACTIVE) any_open = 1'b1;
        viol = (cmd != CMD_NOP) && (rfc_cnt != '0);
        case (cmd)
            CMD_ACTIVE:          if (bank_open || rp_cnt[dram_ba] != '0) viol = 1'b1;
            CMD_READ, CMD_WRITE: if (!bank_open || rcd_cnt[dram_ba] != '0) viol = 1'b1;
            CMD_REFRESH:         if (any_open) viol = 1'b1;
            default: ;
        endcase
    end

    // Counters hold the cycles still to wait; loads override the decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                rcd_cnt[i] <= '0;
                rp_cnt[i]  <= '0;
            end
            rfc_cnt <= '0;
            err     <= 1'b0;
        end else if (dram_cke) begin
            err <= viol;
            for (int i = 0; i < 4; i++) begin
                if (rcd_cnt[i] != '0) rcd_cnt[i] <= rcd_cnt[i] - CW'(1);
                if (rp_cnt[i] != '0)  rp_cnt[i]  <= rp_cnt[i] - CW'(1);
                if (cmd == CMD_ACTIVE && dram_ba == 2'(i)) rcd_cnt[i] <= CW'(T_RCD - 1);
                if (cmd == CMD_PRECHARGE && (dram_addr[10] || dram_ba == 2'(i)))
                    rp_cnt[i] <= CW'(T_RP - 1);
            end
            if (cmd == CMD_REFRESH)   rfc_cnt <= CW'(T_RFC - 1);
            else if (rfc_cnt != '0)   rfc_cnt <= rfc_cnt - CW'(1);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder: a command-level reference model
// schedules whole bursts and predicts each read beat's output cycle and data.
module tb_sdram_responder;
    import sdram_responder_pkg::*;

    localparam int RK = 4, CK = 6, AW = 2 + RK + CK;
    localparam int T_RCD = 3, T_RP = 3, T_RFC = 9;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dram_cke = 1'b1, dram_cs_n = 1'b0;
    logic        dram_ras_n = 1'b1, dram_cas_n = 1'b1, dram_we_n = 1'b1;
    logic [1:0]  dram_ba = '0;
    logic [12:0] dram_addr = '0;
    logic [1:0]  dram_dqm = '0;
    logic [15:0] dram_dq_in = '0;
    logic [15:0] dram_dq_out;
    logic        dram_dq_oe, err;

    sdram_responder #(.ROW_KEEP(RK), .COL_KEEP(CK), .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC)) dut (
        .clk(clk), .reset_n(reset_n), .dram_cke(dram_cke), .dram_cs_n(dram_cs_n),
        .dram_ras_n(dram_ras_n), .dram_cas_n(dram_cas_n), .dram_we_n(dram_we_n),
        .dram_ba(dram_ba), .dram_addr(dram_addr), .dram_dqm(dram_dqm),
        .dram_dq_in(dram_dq_in), .dram_dq_out(dram_dq_out), .dram_dq_oe(dram_dq_oe), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Scoreboard: expected read beats (data, output cycle, don't-care) and err per edge.
    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    bit          exp_dc_q[$];
    logic        err_exp_q[$];

    typedef struct { int edge_no; bit rd; int a; int ba; int ap_bank; } beat_t;
    beat_t sched[$];

    bit          m_open[4];
    int          m_row[4];
    logic [15:0] m_mem[int];
    int          m_bl, m_cl;
    int          last_act[4], last_pre[4], last_ref;
    int          edge_n = 0;
    bit          last_edge_cke = 1'b0, in_reset = 1'b1;

    function automatic int maddr(int ba, int row, int col);
        logic [AW-1:0] a;
        a = {ba[1:0], row[RK-1:0], col[CK-1:0]};
        return int'(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_open[i] = 0; m_row[i] = 0; last_act[i] = -100; last_pre[i] = -100;
        end
        last_ref = -100; m_bl = 1; m_cl = 3;
        sched.delete(); exp_q.delete(); exp_cyc_q.delete(); exp_dc_q.delete(); err_exp_q.delete();
    endtask

    task automatic model_edge();
        logic [2:0]  c;
        logic [15:0] w;
        bit          viol, any;
        int          ba, a, n, col;
        beat_t       b;
        in_reset = 0;
        if (!dram_cke) begin
            last_edge_cke = 0;
            return;
        end
        last_edge_cke = 1;
        edge_n++;
        n = edge_n;
        c = dram_cs_n ? CMD_NOP : {dram_ras_n, dram_cas_n, dram_we_n};
        ba = int'(dram_ba);
        a = int'(dram_addr);
        viol = (c != CMD_NOP) && (n - last_ref < T_RFC);
        case (c)
            CMD_ACTIVE: begin
                if (m_open[ba] || n - last_pre[ba] < T_RP) viol = 1;
                m_open[ba] = 1; m_row[ba] = a; last_act[ba] = n;
            end
            CMD_READ, CMD_WRITE: begin
                if (!m_open[ba]) viol = 1;
                else begin
                    if (n - last_act[ba] < T_RCD) viol = 1;
                    sched.delete();
                    if (c == CMD_WRITE)
                        while (exp_cyc_q.size() > 0 && exp_cyc_q[$] >= n) begin
                            void'(exp_q.pop_back()); void'(exp_cyc_q.pop_back()); void'(exp_dc_q.pop_back());
                        end
                    for (int i = 0; i < m_bl; i++) begin
                        col = (a & ~(m_bl - 1)) | ((a + i) & (m_bl - 1));
                        b.edge_no = n + i; b.rd = (c == CMD_READ); b.a = maddr(ba, m_row[ba], col);
                        b.ba = ba; b.ap_bank = (i == m_bl - 1 && a[10]) ? ba : -1;
                        sched.push_back(b);
                    end
                end
            end
            CMD_PRECHARGE: begin
                for (int i = 0; i < 4; i++)
                    if (a[10] || i == ba) begin m_open[i] = 0; last_pre[i] = n; end
                if (sched.size() > 0 && (a[10] || sched[0].ba == ba)) sched.delete();
            end
            CMD_BST: sched.delete();
            CMD_REFRESH: begin
                any = 0;
                for (int i = 0; i < 4; i++) any |= m_open[i];
                if (any) viol = 1;
                last_ref = n;
            end
            CMD_LOAD_MODE: begin
                case (a & 7) 1: m_bl = 2; 2: m_bl = 4; 3: m_bl = 8; default: m_bl = 1; endcase
                m_cl = (((a >> 4) & 7) == 2) ? 2 : 3;
            end
            default: ;
        endcase
        if (sched.size() > 0 && sched[0].edge_no == n) begin
            b = sched.pop_front();
            if (b.rd) begin
                if (dram_dqm == 2'b00) begin
                    w = m_mem.exists(b.a) ? m_mem[b.a] : 16'hxxxx;
                    exp_q.push_back(w); exp_cyc_q.push_back(n + m_cl - 1); exp_dc_q.push_back($isunknown(w));
                end
            end else begin
                w = m_mem.exists(b.a) ? m_mem[b.a] : 16'hxxxx;
                if (!dram_dqm[0]) w[7:0]  = dram_dq_in[7:0];
                if (!dram_dqm[1]) w[15:8] = dram_dq_in[15:8];
                m_mem[b.a] = w;
            end
            if (b.ap_bank >= 0) m_open[b.ap_bank] = 0;
        end
`ifdef SDRAM_RESPONDER_CHECK_EN
        err_exp_q.push_back(viol);
`else
        err_exp_q.push_back(1'b0);
`endif
    endtask

    task automatic drive(input bit cke, input bit cs_n, input logic [2:0] c, input int ba,
                         input int addr, input logic [1:0] dqm, input logic [15:0] dq);
        dram_cke = cke; dram_cs_n = cs_n;
        {dram_ras_n, dram_cas_n, dram_we_n} = c;
        dram_ba = 2'(ba); dram_addr = 13'(addr); dram_dqm = dqm; dram_dq_in = dq;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cmd(input logic [2:0] c, input int ba, input int addr);
        drive(1, 0, c, ba, addr, 2'b00, 16'($urandom));
    endtask

    task automatic nops(input int k);
        for (int i = 0; i < k; i++) cmd(CMD_NOP, 0, 0);
    endtask

    task automatic write_burst(input int ba, input int col, input int len);
        drive(1, 0, CMD_WRITE, ba, col, 2'b00, 16'($urandom));
        for (int i = 1; i < len; i++) drive(1, 0, CMD_NOP, 0, 0, 2'b00, 16'($urandom));
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // Monitor: pops expected beats as the DUT presents them; checks err every edge.
    logic [15:0] prev_out;
    logic        prev_oe, prev_err;
    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                if (!last_edge_cke) begin
                    check("freeze_hold", {dram_dq_oe, err, dram_dq_out[13:0]},
                          {prev_oe, prev_err, prev_out[13:0]});
                end else begin
                    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < edge_n) begin
                        checks++; failures++;
                        $display("FAIL missed_beat cycle=%0d now=%0d", exp_cyc_q[0], edge_n);
                        void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front()); void'(exp_dc_q.pop_front());
                    end
                    exp_v = exp_cyc_q.size() > 0 && exp_cyc_q[0] == edge_n;
                    check("dq_oe", {15'd0, dram_dq_oe}, {15'd0, exp_v});
                    if (exp_v) begin
                        if (dram_dq_oe && !exp_dc_q[0]) check("dq_out", dram_dq_out, exp_q[0]);
                        void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front()); void'(exp_dc_q.pop_front());
                    end
                    if (err_exp_q.size() > 0) check("err", {15'd0, err}, {15'd0, err_exp_q.pop_front()});
                end
            end
            prev_out = dram_dq_out; prev_oe = dram_dq_oe; prev_err = err;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, ba;
        for (int i = 0; i < 4; i++) m_row[i] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_dq_out", dram_dq_out, 16'h0000);
        check("reset_oe_err", {14'd0, dram_dq_oe, err}, 16'h0000);
        reset_n = 1'b1;
        model_reset();

        // BL4/CL3 wrap: beats read from col 2 come back 3333,4444,1111,2222
        cmd(CMD_LOAD_MODE, 0, 'h032);
        cmd(CMD_ACTIVE, 1, 5);
        nops(3);
        drive(1, 0, CMD_WRITE, 1, 0, 2'b00, 16'h1111);
        drive(1, 0, CMD_NOP, 0, 0, 2'b00, 16'h2222);
        drive(1, 0, CMD_NOP, 0, 0, 2'b00, 16'h3333);
        drive(1, 0, CMD_NOP, 0, 0, 2'b00, 16'h4444);
        cmd(CMD_READ, 1, 2);
        nops(8);

        // CL2/BL1 with upper-byte mask
        cmd(CMD_LOAD_MODE, 0, 'h020);
        drive(1, 0, CMD_WRITE, 1, 8, 2'b00, 16'hFFFF);
        drive(1, 0, CMD_WRITE, 1, 8, 2'b10, 16'hABCD);
        nops(1);
        cmd(CMD_READ, 1, 8);
        nops(4);

        // BL8 read terminated at beat 3; bank stays open for the next read
        cmd(CMD_LOAD_MODE, 0, 'h033);
        write_burst(1, 16, 8);
        cmd(CMD_READ, 1, 16);
        nops(2);
        cmd(CMD_BST, 0, 0);
        nops(6);
        cmd(CMD_READ, 1, 20);
        nops(1);
        for (int i = 0; i < 3; i++) drive(0, 0, CMD_NOP, 0, 0, 2'b00, 16'h0);
        nops(12);

        // READ to an idle bank, then ACTIVE->READ inside T_RCD
        cmd(CMD_READ, 2, 0);
        nops(4);
        cmd(CMD_PRECHARGE, 1, 0);
        nops(3);
        cmd(CMD_ACTIVE, 1, 5);
        cmd(CMD_READ, 1, 16);
        nops(12);

        // Reset in the middle of a read burst
        cmd(CMD_READ, 1, 16);
        nops(2);
        #1 reset_n = 1'b0;
        in_reset = 1;
        #1 check("reset_mid_oe", {15'd0, dram_dq_oe}, 16'h0000);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        cmd(CMD_READ, 1, 16);
        nops(6);

        // Randomised segments
        for (int seg = 0; seg < 5; seg++) begin
            cmd(CMD_LOAD_MODE, 0, ($urandom_range(0, 7) << 4) | $urandom_range(0, 5));
            nops(T_RFC);
            for (int k = 0; k < 90; k++) begin
                r = $urandom_range(0, 99);
                ba = $urandom_range(0, 3);
                if (r < 28) cmd(CMD_NOP, 0, 0);
                else if (r < 42) cmd(CMD_ACTIVE, ba, $urandom_range(0, 3) | ($urandom_range(0, 1) << 8));
                else if (r < 62 || r < 80)
                    drive(1, 0, (r < 62) ? CMD_READ : CMD_WRITE, ba,
                          $urandom_range(0, 63) | (($urandom_range(0, 3) == 0) ? 1024 : 0) | ($urandom_range(0, 1) << 7),
                          ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(0, 3)), 16'($urandom));
                else if (r < 86) cmd(CMD_PRECHARGE, ba, $urandom_range(0, 1) << 10);
                else if (r < 89) cmd(CMD_BST, 0, 0);
                else if (r < 91) cmd(CMD_REFRESH, 0, 0);
                else if (r < 95) drive(1, 1, 3'($urandom_range(0, 7)), ba, $urandom_range(0, 63), 2'b00, 16'($urandom));
                else drive(0, 0, CMD_NOP, 0, 0, 2'b00, 16'($urandom));
            end
            nops(T_RFC + 2);
        end

        nops(4);
        check("queue_drained", 16'(exp_q.size() + sched.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable responder for the DE1-SoC SDR SDRAM pin interface, the device end of the bus our Qsys SDRAM controller drives. It decodes CS/RAS/CAS/WE commands, tracks open rows per bank, serves read bursts through a CAS-latency pipeline, and absorbs write bursts into a small on-chip backing store. It replaces the physical IS42S16320 chip in loopback builds and simulation. The SDRAM controller's pins connect straight to it, with DQ split into in/out/oe.

## Interface
Parameters:
- ROW_KEEP, 4: low row-address bits retained in the backing store.
- COL_KEEP, 6: low column-address bits retained; store depth is 4·2^(ROW_KEEP+COL_KEEP) words × 16 bits.
- T_RCD, 3: minimum cycles from ACTIVE to READ/WRITE on the same bank (checker only).
- T_RP, 3: minimum cycles from PRECHARGE to ACTIVE on the same bank (checker only).
- T_RFC, 9: minimum cycles from AUTO REFRESH to the next non-NOP command (checker only).

Ports:
- clk, in, 1: the SDRAM clock (pll_0_sdram_clk); single clock domain.
- reset_n, in, 1: asynchronous, active-low reset.
- dram_cke, in, 1: clock enable.
- dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, in, 1 each: command.
- dram_ba, in, 2: bank address.
- dram_addr, in, 13: row, column, or mode value; bit 10 selects auto-precharge or all-bank precharge.
- dram_dqm, in, 2: {UDQM, LDQM} byte masks.
- dram_dq_in, in, 16: write data.
- dram_dq_out, out, 16: read data.
- dram_dq_oe, out, 1: read data is being driven.
- err, out, 1: one-cycle protocol-violation pulse.

## Operation
- Commands are decoded on each rising edge when cke=1 and cs_n=0; {ras_n,cas_n,we_n}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE, 110 BURST TERMINATE.
- cs_n=1 is treated as NOP.
- cke=0 freezes all state: burst counters, CL pipeline, and outputs hold.
- Per-bank state is IDLE or ACTIVE(row). ACTIVE latches the row.
  - PRECHARGE with addr[10]=1 closes all banks; with addr[10]=0 it closes bank ba.
  - READ/WRITE with addr[10]=1 closes the bank after the last beat.
- LOAD MODE: addr[2:0] sets the burst length (000=1, 001=2, 010=4, 011=8; other values are treated as 1); addr[6:4] sets the CAS latency (2 or 3; other values are treated as 3). Burst type is sequential only, with the column wrapping inside the aligned BL block.
- Burst engine is IDLE, RD, or WR, with a beat counter 0..BL-1.
  - A new READ/WRITE truncates the current burst and starts the new one.
  - BURST TERMINATE or PRECHARGE of the burst bank ends the burst. Read beats already in the CL pipeline still emerge.
- Store address = {ba, row[ROW_KEEP-1:0], col[COL_KEEP-1:0]}; higher bits are ignored, so aliasing is intended.
- Write beats: each byte lane is written unless its DQM bit is 1 in the same cycle.
- Read beats: the dram_dqm value present at the beat's issue edge is carried 2 cycles. The outgoing beat is masked (oe=0 for that beat) if either DQM bit was 1.
- AUTO REFRESH has no effect on data.

## Timing
- Reset values:
  - dram_dq_out = 0, dram_dq_oe = 0, err = 0.
  - All banks IDLE, burst engine IDLE.
  - Mode: CL=3, BL=1.
- Read latency: READ sampled at edge t drives beat i after edge t+CL-1+i, held until edge t+CL+i. oe is high for exactly BL cycles when untruncated.
- The store read is synchronous (1 cycle); the remaining CL-2 cycles are a shift pipeline.
- Write: the beat-0 data is sampled with the WRITE command at edge t; beat i is sampled at edge t+i.
- A READ after a WRITE truncates the write at the READ edge.
- A WRITE during read output turns oe off from the WRITE edge; pending read data is discarded.
- A read or write to an IDLE bank is ignored and flags err.
- Reset asserted mid-burst clears everything immediately; oe drops asynchronously.

## Configuration
- SDRAM_RESPONDER_CHECK_EN defined: the protocol checker is compiled in.
  - Per-bank T_RCD and T_RP countdown counters, plus a global T_RFC counter.
  - err pulses for each of: ACTIVE on an ACTIVE bank, READ/WRITE to an IDLE bank, REFRESH with any bank ACTIVE, or any timing violation.
  - Violating commands are still executed, except READ/WRITE to an IDLE bank, which is ignored.
- Not defined: err is tied 0 and no counters are present. The READ/WRITE-to-IDLE-bank ignore rule still applies.

## Structure
- A shared package sdram_responder_pkg holds:
  - the command encoding constants
  - the bank-state and burst-state enums
  - the mode-field decode functions (BL, CL)
- One sub-module, sdram_responder_mem: a byte-enabled single-port synchronous RAM of 16-bit words, depth set by ROW_KEEP/COL_KEEP, inferrable as M10K.

## Test plan
- LOAD MODE addr=0x032 (CL=3, BL=4); ACTIVE ba=1 row=5; after 3 NOPs, WRITE col=0 with data 0x1111,0x2222,0x3333,0x4444; READ col=2 → oe rises after edge t+2; beats 0x3333,0x4444,0x1111,0x2222.
- CL=2, BL=1: write 0xABCD with dqm=2'b10 over 0xFFFF → read returns 0xFFCD, one cycle earlier than with CL=3.
- BL=8 READ, then BURST TERMINATE at beat 3 → exactly 3+CL-pipeline beats are driven, then oe=0; bank stays ACTIVE.
- READ to an IDLE bank → oe stays 0; err=1 for one cycle (with CHECK_EN), err=0 without it.
- (CHECK_EN) ACTIVE then READ 1 cycle later with T_RCD=3 → err pulse; data is still returned correctly.
- Assert reset_n=0 mid read burst → dq_oe=0 immediately; after release, READ to the previously open bank flags err (bank IDLE).
